// File: rtl/stage0_ctrl_if.sv
// Control/handshake bundle between the stage0 sequencer and its neighbours.
// master = upstream/DMA side, slave = the sequencer itself.
interface stage0_ctrl_if;
    logic start;
    logic relu_cfg;
    logic cfg_valid;
    logic cfg_ready;
    logic pix_valid;
    logic pix_ready;
    logic weight_en;
    logic weight_mode;
    logic relu_sel;
    logic out_valid;
    logic busy;
    logic done;
    logic err_underrun;

    modport master (
        output start, relu_cfg, cfg_valid, pix_valid,
        input  cfg_ready, pix_ready, weight_en, weight_mode, relu_sel,
               out_valid, busy, done, err_underrun
    );

    modport slave (
        input  start, relu_cfg, cfg_valid, pix_valid,
        output cfg_ready, pix_ready, weight_en, weight_mode, relu_sel,
               out_valid, busy, done, err_underrun
    );
endinterface

// File: rtl/stage0_ctrl.sv
// Sequencer for one depthwise stage: loads kernel weights and BN config into the
// DW_BN_ReLU chain, then admits one frame of pixels and flags valid stage outputs.
module stage0_ctrl #(
    parameter int int_bits = 13,
    parameter int N_PE     = 9,
    parameter int W_TAPS   = 9,
    parameter int ROW_LEN  = 32,
    parameter int ROWS     = 32,
    parameter int PIPE_LAT = 3
) (
    input  logic         clk,
    input  logic         reset,
    stage0_ctrl_if.slave bus
);
    localparam int CFG_W_BEATS = N_PE * W_TAPS;
    localparam int CFG_CW      = (CFG_W_BEATS > 1) ? $clog2(CFG_W_BEATS) : 1;
    localparam int COL_CW      = $clog2(ROW_LEN);
    localparam int ROW_CW      = $clog2(ROWS);
    localparam int DRN_CW      = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [CFG_CW-1:0] CFG_W_LAST  = CFG_CW'(CFG_W_BEATS - 1);
    localparam logic [CFG_CW-1:0] CFG_BN_LAST = CFG_CW'(N_PE - 1);
    localparam logic [COL_CW-1:0] COL_LAST    = COL_CW'(ROW_LEN - 1);
    localparam logic [ROW_CW-1:0] ROW_LAST    = ROW_CW'(ROWS - 1);
    localparam logic [ROW_CW-1:0] ROW_PRIMED  = ROW_CW'(2);
    localparam logic [DRN_CW-1:0] DRN_LAST    = DRN_CW'(PIPE_LAT - 1);

    if (int_bits < 1 || N_PE < 1 || W_TAPS < 1 || ROW_LEN < 2 || ROWS < 3 || PIPE_LAT < 1)
    begin : g_bad_param
        $error("stage0_ctrl: illegal parameter set");
    end

    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_LOAD_BN, S_RUN, S_DRAIN} state_t;

    state_t              state_q, state_d;
    logic [CFG_CW-1:0]   cfg_cnt_q, cfg_cnt_d;
    logic [COL_CW-1:0]   col_q, col_d;
    logic [ROW_CW-1:0]   row_q, row_d;
    logic [DRN_CW-1:0]   drn_q, drn_d;
    logic [PIPE_LAT-1:0] vld_q, vld_d;
    logic                relu_q, relu_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                cfg_ready_q, cfg_ready_d;
    logic                wmode_q, wmode_d;
    logic                pix_ready_q, pix_ready_d;
    logic                done_q, done_d;
    logic                beat_cfg;
    logic                push;

    assign beat_cfg = bus.cfg_valid & cfg_ready_q;

    always_comb begin
        state_d   = state_q;
        cfg_cnt_d = cfg_cnt_q;
        col_d     = col_q;
        row_d     = row_q;
        drn_d     = drn_q;
        vld_d     = vld_q;
        relu_d    = relu_q;
        err_d     = err_q;
        push      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_LOAD_W;
                    cfg_cnt_d = '0;
                    relu_d    = bus.relu_cfg;
                    err_d     = 1'b0;
                end
            end
            S_LOAD_W: begin
                if (beat_cfg) begin
                    if (cfg_cnt_q == CFG_W_LAST) begin
                        state_d   = S_LOAD_BN;
                        cfg_cnt_d = '0;
                    end else begin
                        cfg_cnt_d = cfg_cnt_q + 1'b1;
                    end
                end
            end
            S_LOAD_BN: begin
                if (beat_cfg) begin
                    if (cfg_cnt_q == CFG_BN_LAST) begin
                        state_d   = S_RUN;
                        cfg_cnt_d = '0;
                        col_d     = '0;
                        row_d     = '0;
                    end else begin
                        cfg_cnt_d = cfg_cnt_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                // The datapath never stalls, so a missing pixel is a bubble, not a hold.
                if (bus.pix_valid) begin
                    push = (row_q >= ROW_PRIMED);
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            state_d = S_DRAIN;
                            drn_d   = '0;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end else begin
                    err_d = 1'b1;
                end
                vld_d = (vld_q << 1) | PIPE_LAT'(push);
            end
            S_DRAIN: begin
                vld_d = vld_q << 1;
                if (drn_q == DRN_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    drn_d = drn_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d      = (state_d != S_IDLE);
        cfg_ready_d = (state_d == S_LOAD_W) || (state_d == S_LOAD_BN);
        wmode_d     = (state_d == S_LOAD_BN);
        pix_ready_d = (state_d == S_RUN);
        done_d      = (state_d == S_DRAIN) && (drn_d == DRN_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cfg_cnt_q   <= '0;
            col_q       <= '0;
            row_q       <= '0;
            drn_q       <= '0;
            vld_q       <= '0;
            relu_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b0;
            wmode_q     <= 1'b0;
            pix_ready_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_cnt_q   <= cfg_cnt_d;
            col_q       <= col_d;
            row_q       <= row_d;
            drn_q       <= drn_d;
            vld_q       <= vld_d;
            relu_q      <= relu_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            cfg_ready_q <= cfg_ready_d;
            wmode_q     <= wmode_d;
            pix_ready_q <= pix_ready_d;
            done_q      <= done_d;
        end
    end

    assign bus.cfg_ready    = cfg_ready_q;
    assign bus.pix_ready    = pix_ready_q;
    assign bus.weight_en    = beat_cfg;
    assign bus.weight_mode  = wmode_q;
    assign bus.relu_sel     = relu_q;
    assign bus.out_valid    = vld_q[PIPE_LAT-1];
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err_underrun = err_q;
endmodule

// File: tb/tb_stage0_ctrl.sv
// Scoreboard bench for stage0_ctrl: a frame-level model issues per-cycle expectations
// and output-valid timestamps; a negedge monitor pops and compares them.
module tb_stage0_ctrl;
    localparam int N_PE     = 9;
    localparam int W_TAPS   = 9;
    localparam int ROW_LEN  = 32;
    localparam int ROWS     = 32;
    localparam int PIPE_LAT = 3;
    localparam int CFG_W    = N_PE * W_TAPS;
    localparam int CFG_TOT  = CFG_W + N_PE;
    localparam int PIX_TOT  = ROWS * ROW_LEN;
    localparam int OV_TOT   = (ROWS - 2) * ROW_LEN;
    localparam int BUDGET   = 20000;

    typedef struct packed {
        bit busy, cfg_ready, weight_en, weight_mode, pix_ready, done, err, relu;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    stage0_ctrl_if bus ();

    stage0_ctrl #(.int_bits(13), .N_PE(N_PE), .W_TAPS(W_TAPS), .ROW_LEN(ROW_LEN),
                  .ROWS(ROWS), .PIPE_LAT(PIPE_LAT))
        u_dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard queues and frame-level model state
    exp_t exp_q[$];
    int   exp_ov_q[$];
    bit   m_act, m_err, m_relu;
    int   m_cfg, m_pix, m_since;
    int   ov_cnt, we0_cnt, we1_cnt, done_cnt, pr_cnt;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    exp_t mon_e;
    bit   mon_ov;
    always @(negedge clk) begin
        if (!reset) begin
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("busy",         bus.busy,         mon_e.busy);
                check("cfg_ready",    bus.cfg_ready,    mon_e.cfg_ready);
                check("weight_en",    bus.weight_en,    mon_e.weight_en);
                if (mon_e.weight_en) check("weight_mode", bus.weight_mode, mon_e.weight_mode);
                check("pix_ready",    bus.pix_ready,    mon_e.pix_ready);
                check("done",         bus.done,         mon_e.done);
                check("err_underrun", bus.err_underrun, mon_e.err);
                check("relu_sel",     bus.relu_sel,     mon_e.relu);
            end
            mon_ov = (exp_ov_q.size() > 0) && (exp_ov_q[0] == cyc);
            if (mon_ov) void'(exp_ov_q.pop_front());
            if (bus.out_valid || mon_ov) check("out_valid", bus.out_valid, mon_ov);
            if (bus.out_valid) ov_cnt++;
            if (bus.weight_en && !bus.weight_mode) we0_cnt++;
            if (bus.weight_en && bus.weight_mode) we1_cnt++;
            if (bus.done) done_cnt++;
            if (bus.pix_ready) pr_cnt++;
        end
    end

    function automatic bit in_cfg();
        return m_act && (m_cfg < CFG_TOT);
    endfunction
    function automatic bit in_run();
        return m_act && (m_cfg == CFG_TOT) && (m_pix < PIX_TOT);
    endfunction
    function automatic bit draining();
        return m_act && (m_pix == PIX_TOT);
    endfunction

    // Issue this cycle's expectation, advance the model across the edge, then move on.
    task automatic step();
        exp_t e;
        e.busy        = m_act;
        e.cfg_ready   = in_cfg();
        e.weight_en   = in_cfg() && bus.cfg_valid;
        e.weight_mode = in_cfg() && (m_cfg >= CFG_W);
        e.pix_ready   = in_run();
        e.done        = draining() && (m_since == PIPE_LAT - 1);
        e.err         = m_err;
        e.relu        = m_relu;
        exp_q.push_back(e);
        if (!m_act) begin
            if (bus.start) begin
                m_act = 1; m_cfg = 0; m_pix = 0; m_err = 0; m_relu = bus.relu_cfg;
            end
        end else if (in_cfg()) begin
            if (bus.cfg_valid) m_cfg++;
        end else if (in_run()) begin
            if (bus.pix_valid) begin
                if (m_pix >= 2 * ROW_LEN) exp_ov_q.push_back(cyc + PIPE_LAT);
                m_pix++;
                if (m_pix == PIX_TOT) m_since = 0;
            end else begin
                m_err = 1;
            end
        end else begin
            if (m_since == PIPE_LAT - 1) m_act = 0;
            else m_since++;
        end
        @(posedge clk); #1;
    endtask

    task automatic reset_and_check();
        reset = 1'b1;
        exp_q.delete();
        exp_ov_q.delete();
        m_act = 0; m_err = 0; m_relu = 0; m_cfg = 0; m_pix = 0; m_since = 0;
        @(negedge clk);
        check("rst_busy",      bus.busy,         0);
        check("rst_cfg_ready", bus.cfg_ready,    0);
        check("rst_pix_ready", bus.pix_ready,    0);
        check("rst_wmode",     bus.weight_mode,  0);
        check("rst_out_valid", bus.out_valid,    0);
        check("rst_done",      bus.done,         0);
        check("rst_err",       bus.err_underrun, 0);
        check("rst_relu",      bus.relu_sel,     0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // cfg_mode/pix_mode: 0 always valid, 1 toggled cfg / single pixel gap at row 10, 2 random
    task automatic run_frame(input int cfg_mode, input int pix_mode, input bit rc,
                             input bit strays, input int rst_row);
        int  n;
        bit  gap_done;
        ov_cnt = 0; we0_cnt = 0; we1_cnt = 0; done_cnt = 0; pr_cnt = 0;
        bus.start = 1'b1; bus.relu_cfg = rc; bus.cfg_valid = 1'b0; bus.pix_valid = 1'b1;
        step();
        bus.start = 1'b0;
        n = 0; gap_done = 0;
        while (m_act && n < BUDGET) begin
            case (cfg_mode)
                0:       bus.cfg_valid = 1'b1;
                1:       bus.cfg_valid = ~bus.cfg_valid;
                default: bus.cfg_valid = ($urandom_range(0, 2) != 0);
            endcase
            case (pix_mode)
                0: bus.pix_valid = 1'b1;
                1: begin
                    bus.pix_valid = 1'b1;
                    if (!gap_done && in_run() && m_pix == 10 * ROW_LEN + 5) begin
                        bus.pix_valid = 1'b0;
                        gap_done = 1;
                    end
                end
                default: bus.pix_valid = ($urandom_range(0, 3) != 0);
            endcase
            bus.start = strays && ((in_cfg() && m_cfg == 40) || (in_run() && m_pix == 300) ||
                                   (draining() && m_since == PIPE_LAT - 1));
            bus.relu_cfg = ~rc;
            if (rst_row >= 0 && in_run() && m_pix == rst_row * ROW_LEN) begin
                reset_and_check();
                return;
            end
            step();
            n++;
        end
        bus.start = 1'b0;
        check("frame_finished", m_act, 0);
        check("cnt_out_valid",  ov_cnt,   OV_TOT);
        check("cnt_wen_mode0",  we0_cnt,  CFG_W);
        check("cnt_wen_mode1",  we1_cnt,  N_PE);
        check("cnt_done",       done_cnt, 1);
        check("cnt_pix_ready",  pr_cnt - (m_err ? pr_cnt - PIX_TOT : 0), PIX_TOT);
        check("ov_queue_empty", exp_ov_q.size(), 0);
    endtask

    task automatic idle(input int k);
        bus.start = 1'b0; bus.cfg_valid = 1'b0; bus.pix_valid = 1'b0;
        for (int i = 0; i < k; i++) step();
    endtask

    initial begin
        bus.start = 1'b0; bus.relu_cfg = 1'b0; bus.cfg_valid = 1'b0; bus.pix_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_and_check();
        idle(3);
        run_frame(0, 0, 1'b1, 1'b1, -1);
        idle(3);
        check("err_clean_frame", bus.err_underrun, 0);
        run_frame(1, 1, 1'b0, 1'b0, -1);
        check("err_after_gap", bus.err_underrun, 1);
        idle(2);
        run_frame(0, 0, 1'b0, 1'b0, -1);
        check("err_cleared", bus.err_underrun, 0);
        idle(2);
        run_frame(2, 2, $urandom_range(0, 1) != 0, 1'b0, -1);
        idle(2);
        run_frame(0, 0, 1'b1, 1'b0, 5);
        idle(2);
        run_frame(0, 0, 1'b0, 1'b0, -1);
        idle(4);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
